// File: rtl/ch0re_ifetch_if.sv
// Fetch-unit bus: instruction-memory port plus the valid/ready link to decode.
// master = fetch unit side, slave = memory/decode side.
interface ch0re_ifetch_if #(
    parameter int IMEM_ADDR_WIDTH = 11
);
    logic                       o_imem_ren;
    logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr;
    logic [31:0]                i_imem_rdata;
    logic                       i_redirect;
    logic [63:0]                i_redirect_pc;
    logic                       o_valid;
    logic                       i_ready;
    logic [63:0]                o_pc;
    logic [31:0]                o_instr;
    logic                       o_misaligned;

    modport master (
        output o_imem_ren, o_imem_addr, o_valid, o_pc, o_instr, o_misaligned,
        input  i_imem_rdata, i_redirect, i_redirect_pc, i_ready
    );

    modport slave (
        input  o_imem_ren, o_imem_addr, o_valid, o_pc, o_instr, o_misaligned,
        output i_imem_rdata, i_redirect, i_redirect_pc, i_ready
    );
endinterface

// File: rtl/ch0re_ifetch.sv
// ch0re RV64I instruction fetch: credit-limited requests to a 1-cycle imem,
// 2-entry output buffer, redirect flush and misaligned-target trap reporting.
module ch0re_ifetch #(
    parameter int          IMEM_ADDR_WIDTH = 11,
    parameter logic [63:0] RESET_PC        = 64'h0
) (
    input logic            clk,
    input logic            rst,
    ch0re_ifetch_if.master bus
);
    typedef enum logic [1:0] {RUN, TRAP, HALT} state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] trap_pc;
    logic [63:0] inflight_pc;
    logic        inflight;

    logic [63:0] buf_pc    [2];
    logic [31:0] buf_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  occ;

    logic        redir_ok;
    logic        redir_bad;
    logic        pop;
    logic        pop_run;
    logic        push;
    logic        issue;
    logic        credits_full;
    logic [2:0]  credit_sum;
    logic [63:0] issue_pc;

    always_comb begin
        redir_ok     = bus.i_redirect && (bus.i_redirect_pc[1:0] == 2'b00);
        redir_bad    = bus.i_redirect && (bus.i_redirect_pc[1:0] != 2'b00);
        issue_pc     = bus.i_redirect ? bus.i_redirect_pc : pc;
        credit_sum   = {1'b0, occ} + {2'b00, inflight};
        credits_full = (credit_sum >= 3'd2);

        // A redirect cycle never presents anything, so it can never pop.
        bus.o_valid  = !rst && !bus.i_redirect &&
                       ((state == RUN && occ != 2'd0) || state == TRAP);
        pop          = bus.o_valid && bus.i_ready;
        pop_run      = pop && (state == RUN);
        push         = (state == RUN) && inflight && !bus.i_redirect;

        // With full credits, a same-cycle pop frees the slot the response will need.
        issue        = !rst && (redir_ok ||
                       (state == RUN && !bus.i_redirect && (!credits_full || pop)));

        bus.o_imem_ren   = issue;
        bus.o_imem_addr  = issue_pc[IMEM_ADDR_WIDTH+1:2];
        bus.o_misaligned = bus.o_valid && (state == TRAP);
        bus.o_pc         = '0;
        bus.o_instr      = '0;
        if (bus.o_valid) begin
            if (state == TRAP) begin
                bus.o_pc    = trap_pc;
                bus.o_instr = 32'h0000_0013;
            end else begin
                bus.o_pc    = buf_pc[rd_ptr];
                bus.o_instr = buf_instr[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= {RESET_PC[63:2], 2'b00};
            trap_pc     <= '0;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            occ         <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
        end else begin
            if (issue) begin
                pc          <= issue_pc + 64'd4;
                inflight_pc <= issue_pc;
            end
            inflight <= issue;

            if (bus.i_redirect) begin
                occ    <= '0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop_run)
                    rd_ptr <= ~rd_ptr;
                occ <= occ + {1'b0, push} - {1'b0, pop_run};
            end

            if (redir_ok) begin
                state <= RUN;
            end else if (redir_bad) begin
                state   <= TRAP;
                trap_pc <= bus.i_redirect_pc;
            end else if (state == TRAP && pop) begin
                state <= HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= inflight_pc;
            buf_instr[wr_ptr] <= bus.i_imem_rdata;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && occ == 2'd2 && !pop));

endmodule

// File: tb/tb_ch0re_ifetch.sv
// Directed bench for ch0re_ifetch: stream-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ch0re_ifetch;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ch0re_ifetch_if #(.IMEM_ADDR_WIDTH(AW)) bus ();

    ch0re_ifetch #(.IMEM_ADDR_WIDTH(AW), .RESET_PC(64'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Instruction memory: word i holds 0x1000 + i, read data one cycle after request.
    logic [31:0] mem [2**AW];
    initial for (int i = 0; i < 2**AW; i++) mem[i] = 32'h1000 + i;
    always @(posedge clk) if (bus.o_imem_ren) bus.i_imem_rdata <= mem[bus.o_imem_addr];

    function automatic logic [31:0] word_at(input logic [63:0] p);
        logic [AW-1:0] idx;
        idx = p[AW+1:2];
        return 32'h1000 + {{(32-AW){1'b0}}, idx};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: after a restart at P the delivered stream is P, P+4, ...
    // and becomes visible two cycles after the restart cycle.
    typedef enum {M_IDLE, M_STREAM, M_TRAP, M_HALT} mode_t;
    mode_t       mode = M_IDLE;
    logic [63:0] exp_pc = '0;
    logic [63:0] exp_trap = '0;
    int          warm = 0;
    bit          after_rst = 0;

    always @(negedge clk) begin
        if (rst) begin
            after_rst = 1;
        end else if (bus.i_redirect) begin
            after_rst = 0;
            chk("m_redir_valid", bus.o_valid, 0);
            if (bus.i_redirect_pc[1:0] == 2'b00) begin
                chk("m_redir_ren", bus.o_imem_ren, 1);
                chk("m_redir_addr", bus.o_imem_addr, bus.i_redirect_pc[AW+1:2]);
                mode   = M_STREAM;
                exp_pc = bus.i_redirect_pc;
                warm   = 1;
            end else begin
                chk("m_redir_bad_ren", bus.o_imem_ren, 0);
                mode     = M_TRAP;
                exp_trap = bus.i_redirect_pc;
            end
        end else if (after_rst) begin
            after_rst = 0;
            chk("m_rst_valid", bus.o_valid, 0);
            chk("m_rst_mis", bus.o_misaligned, 0);
            chk("m_rst_pc", bus.o_pc, 0);
            chk("m_rst_instr", bus.o_instr, 0);
            chk("m_rst_ren", bus.o_imem_ren, 1);
            chk("m_rst_addr", bus.o_imem_addr, 0);
            mode   = M_STREAM;
            exp_pc = 64'h0;
            warm   = 1;
        end else begin
            case (mode)
                M_STREAM: begin
                    if (warm > 0) begin
                        chk("m_warm_valid", bus.o_valid, 0);
                        warm--;
                    end else begin
                        chk("m_valid", bus.o_valid, 1);
                        chk("m_mis", bus.o_misaligned, 0);
                        chk("m_pc", bus.o_pc, exp_pc);
                        chk("m_instr", bus.o_instr, word_at(exp_pc));
                        if (bus.i_ready) exp_pc = exp_pc + 64'd4;
                    end
                end
                M_TRAP: begin
                    chk("m_trap_valid", bus.o_valid, 1);
                    chk("m_trap_mis", bus.o_misaligned, 1);
                    chk("m_trap_pc", bus.o_pc, exp_trap);
                    chk("m_trap_instr", bus.o_instr, 32'h13);
                    chk("m_trap_ren", bus.o_imem_ren, 0);
                    if (bus.i_ready) mode = M_HALT;
                end
                M_HALT: begin
                    chk("m_halt_valid", bus.o_valid, 0);
                    chk("m_halt_ren", bus.o_imem_ren, 0);
                end
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_pulse(input logic [63:0] target);
        step();
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = target;
        @(negedge clk);
        chk("redir_valid_t", bus.o_valid, 0);
        step();
        bus.i_redirect = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_ready       = 1'b1;
        step();
        step();

        // Basic fetch: c0 request, c2 first delivery, then one per cycle.
        rst = 1'b0;
        @(negedge clk); chk("c0_ren", bus.o_imem_ren, 1); chk("c0_valid", bus.o_valid, 0);
        step(); @(negedge clk); chk("c1_valid", bus.o_valid, 0);
        step(); @(negedge clk);
        chk("c2_valid", bus.o_valid, 1); chk("c2_pc", bus.o_pc, 0); chk("c2_instr", bus.o_instr, 32'h1000);
        step(); @(negedge clk); chk("c3_pc", bus.o_pc, 4); chk("c3_instr", bus.o_instr, 32'h1001);
        step(); @(negedge clk); chk("c4_pc", bus.o_pc, 8); chk("c4_instr", bus.o_instr, 32'h1002);
        repeat (4) step();

        // Back-pressure: four stalled cycles hold pc 0x1c with no requests.
        step();
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ren", bus.o_imem_ren, 0);
            chk("bp_pc", bus.o_pc, 64'h1c);
            step();
        end
        bus.i_ready = 1'b1;
        @(negedge clk); chk("bp_rel0", bus.o_pc, 64'h1c);
        step(); @(negedge clk); chk("bp_rel1", bus.o_pc, 64'h20);
        step(); @(negedge clk); chk("bp_rel2", bus.o_pc, 64'h24); chk("bp_rel2_i", bus.o_instr, 32'h1009);
        repeat (3) step();

        // Aligned redirect while a response is in flight.
        redirect_pulse(64'h40);
        @(negedge clk); chk("ar_t1_valid", bus.o_valid, 0);
        step(); @(negedge clk);
        chk("ar_t2_pc", bus.o_pc, 64'h40); chk("ar_t2_instr", bus.o_instr, 32'h1010);
        step(); @(negedge clk); chk("ar_t3_pc", bus.o_pc, 64'h44);
        repeat (3) step();

        // Misaligned redirect: TRAP entry held under stall, then halted.
        bus.i_ready = 1'b0;
        redirect_pulse(64'h42);
        @(negedge clk);
        chk("mr_valid", bus.o_valid, 1); chk("mr_mis", bus.o_misaligned, 1);
        chk("mr_pc", bus.o_pc, 64'h42); chk("mr_instr", bus.o_instr, 32'h13);
        step(); @(negedge clk); chk("mr_hold_pc", bus.o_pc, 64'h42);
        step();
        bus.i_ready = 1'b1;
        @(negedge clk); chk("mr_accept_valid", bus.o_valid, 1);
        for (int i = 0; i < 10; i++) begin
            step(); @(negedge clk);
            chk("halt_valid", bus.o_valid, 0);
            chk("halt_ren", bus.o_imem_ren, 0);
        end
        redirect_pulse(64'h80);
        step(); @(negedge clk);
        chk("resume_pc", bus.o_pc, 64'h80); chk("resume_instr", bus.o_instr, 32'h1020);
        repeat (3) step();

        // Reset mid-stream with a full buffer.
        bus.i_ready = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("mrst_valid", bus.o_valid, 0); chk("mrst_pc", bus.o_pc, 0); chk("mrst_instr", bus.o_instr, 0);
        step(); step(); @(negedge clk);
        chk("mrst_c2_pc", bus.o_pc, 0); chk("mrst_c2_instr", bus.o_instr, 32'h1000);
        repeat (3) step();

        // PC wrap at the top of the address space.
        redirect_pulse(64'hFFFF_FFFF_FFFF_FFFC);
        step(); @(negedge clk);
        chk("wrap_pc0", bus.o_pc, 64'hFFFF_FFFF_FFFF_FFFC); chk("wrap_instr0", bus.o_instr, 32'h17FF);
        step(); @(negedge clk); chk("wrap_pc1", bus.o_pc, 0); chk("wrap_instr1", bus.o_instr, 32'h1000);
        step(); @(negedge clk); chk("wrap_pc2", bus.o_pc, 4); chk("wrap_instr2", bus.o_instr, 32'h1001);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
